// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// with a valid/ready handshake on both the operand and the result side.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt;
    logic             br;

    logic             a_i;
    logic             b_i;
    logic             d_i;
    logic             br_nx;
    logic             ovf_nx;
    logic [WIDTH-1:0] res_nx;

    // Full-subtractor cell on the current bit; the only arithmetic in the block.
    always_comb begin
        a_i         = a_q[cnt];
        b_i         = b_q[cnt];
        d_i         = a_i ^ b_i ^ br;
        br_nx       = (~a_i & b_i) | (~(a_i ^ b_i) & br);
        res_nx      = res_q;
        res_nx[cnt] = d_i;
        ovf_nx      = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ res_nx[WIDTH-1]);
    end

    // Result is assembled in res_q so diff keeps the previous answer until DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            cnt       <= '0;
            br        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        br       <= bin;
                        cnt      <= '0;
                        res_q    <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    res_q <= res_nx;
                    br    <= br_nx;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        diff      <= res_nx;
                        bout      <= br_nx;
                        ovf       <= ovf_nx;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH 1, 8 and 13: directed cases
// on the 8-bit instance, then randomized back-to-back traffic on all three.
module tb_serial_subtractor;

    localparam int unsigned MAXW = 13;

    typedef struct packed {
        logic [MAXW-1:0] d;
        logic            bo;
        logic            ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rnd;

    logic            iv_w   [3];
    logic            ir_w   [3];
    logic            ov_w   [3];
    logic            ordy_w [3];
    logic            bin_w  [3];
    logic            bout_w [3];
    logic            ovf_w  [3];
    logic            busy_w [3];
    logic [MAXW-1:0] a_w    [3];
    logic [MAXW-1:0] b_w    [3];
    logic [MAXW-1:0] diff_w [3];

    logic [0:0]  diff1;
    logic [7:0]  diff8;
    logic [12:0] diff13;

    int   wid [3] = '{1, 8, 13};
    exp_t q   [3][$];
    int   total = 0;
    int   bad   = 0;

    assign diff_w[0] = MAXW'(diff1);
    assign diff_w[1] = MAXW'(diff8);
    assign diff_w[2] = MAXW'(diff13);

    serial_subtractor #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_w[0]), .in_ready(ir_w[0]),
        .a(a_w[0][0:0]), .b(b_w[0][0:0]), .bin(bin_w[0]),
        .out_valid(ov_w[0]), .out_ready(ordy_w[0]), .diff(diff1),
        .bout(bout_w[0]), .ovf(ovf_w[0]), .busy(busy_w[0]));

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_w[1]), .in_ready(ir_w[1]),
        .a(a_w[1][7:0]), .b(b_w[1][7:0]), .bin(bin_w[1]),
        .out_valid(ov_w[1]), .out_ready(ordy_w[1]), .diff(diff8),
        .bout(bout_w[1]), .ovf(ovf_w[1]), .busy(busy_w[1]));

    serial_subtractor #(.WIDTH(13)) u13 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_w[2]), .in_ready(ir_w[2]),
        .a(a_w[2]), .b(b_w[2]), .bin(bin_w[2]),
        .out_valid(ov_w[2]), .out_ready(ordy_w[2]), .diff(diff13),
        .bout(bout_w[2]), .ovf(ovf_w[2]), .busy(busy_w[2]));

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input int w, input logic [MAXW-1:0] a,
                                   input logic [MAXW-1:0] b, input logic bin);
        longint m, av, bv, r, sa, sb, t;
        exp_t   e;
        m    = longint'(1) << w;
        av   = longint'(a) & (m - 1);
        bv   = longint'(b) & (m - 1);
        r    = av - bv - longint'(bin);
        e.d  = MAXW'(r & (m - 1));
        e.bo = (av < bv + longint'(bin));
        sa   = (av >= m / 2) ? av - m : av;
        sb   = (bv >= m / 2) ? bv - m : bv;
        t    = sa - sb - longint'(bin);
        e.ov = (t < -(m / 2)) || (t > m / 2 - 1);
        return e;
    endfunction

    // Monitor: every result handshake pops one expected entry.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                for (int k = 0; k < 3; k++) begin
                    if (ov_w[k] === 1'b1 && ordy_w[k] === 1'b1) begin
                        if (q[k].size() == 0) begin
                            check($sformatf("w%0d spurious result", wid[k]), 1, 0);
                        end else begin
                            e = q[k].pop_front();
                            check($sformatf("w%0d diff", wid[k]), diff_w[k], e.d);
                            check($sformatf("w%0d bout", wid[k]), bout_w[k], e.bo);
                            check($sformatf("w%0d ovf", wid[k]), ovf_w[k], e.ov);
                        end
                    end
                end
            end
        end
    end

    // Random consumer back-pressure during the random phase.
    initial forever begin
        @(posedge clk);
        #1;
        if (rnd) begin
            for (int k = 0; k < 3; k++) ordy_w[k] = ($urandom_range(0, 3) != 0);
        end
    end

    // Directed op on the 8-bit instance; entered mid-cycle with the DUT idle.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bn, input bit hold);
        exp_t e;
        int   n;
        e = model(8, MAXW'(av), MAXW'(bv), bn);
        check("in_ready before accept", ir_w[1], 1);
        a_w[1]    = MAXW'(av);
        b_w[1]    = MAXW'(bv);
        bin_w[1]  = bn;
        iv_w[1]   = 1'b1;
        ordy_w[1] = !hold;
        q[1].push_back(e);
        @(posedge clk);
        #1;
        iv_w[1]  = 1'b0;
        a_w[1]   = MAXW'($urandom);
        b_w[1]   = MAXW'($urandom);
        bin_w[1] = ~bn;
        check("busy after accept", busy_w[1], 1);
        check("in_ready after accept", ir_w[1], 0);
        n = 0;
        while (ov_w[1] !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, 8);
        if (hold) begin
            for (int j = 0; j < 5; j++) begin
                iv_w[1] = (j % 2 == 0);
                a_w[1]  = MAXW'($urandom);
                @(posedge clk);
                #1;
                check("hold diff", diff_w[1], e.d);
                check("hold bout", bout_w[1], e.bo);
                check("hold ovf", ovf_w[1], e.ov);
                check("hold out_valid", ov_w[1], 1);
                check("hold in_ready", ir_w[1], 0);
            end
            iv_w[1]   = 1'b0;
            ordy_w[1] = 1'b1;
        end
        @(posedge clk);
        #1;
        check("out_valid after take", ov_w[1], 0);
        check("in_ready after take", ir_w[1], 1);
        check("busy after take", busy_w[1], 0);
        check("retained diff", diff_w[1], e.d);
    endtask

    // Randomized producer for instance k: n operations, random gaps.
    task automatic drive(input int k, input int n);
        int              waited;
        logic [MAXW-1:0] msk;
        msk = MAXW'((longint'(1) << wid[k]) - 1);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            a_w[k]   = MAXW'($urandom) & msk;
            b_w[k]   = MAXW'($urandom) & msk;
            bin_w[k] = 1'($urandom);
            iv_w[k]  = 1'b1;
            waited   = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (ir_w[k] !== 1'b1 && waited < 200);
            if (ir_w[k] !== 1'b1) begin
                check($sformatf("w%0d accept timeout", wid[k]), 0, 1);
                iv_w[k] = 1'b0;
                return;
            end
            q[k].push_back(model(wid[k], a_w[k], b_w[k], bin_w[k]));
            @(posedge clk);
            #1;
            iv_w[k]  = 1'b0;
            a_w[k]   = MAXW'($urandom);
            b_w[k]   = MAXW'($urandom);
            bin_w[k] = 1'($urandom);
        end
    endtask

    initial begin : main
        int n;
        rnd   = 1'b0;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv_w[k]   = 1'b0;
            ordy_w[k] = 1'b0;
            bin_w[k]  = 1'b0;
            a_w[k]    = '0;
            b_w[k]    = '0;
        end
        #22;
        check("reset out_valid", ov_w[1], 0);
        check("reset busy", busy_w[1], 0);
        check("reset diff", diff_w[1], 0);
        check("reset bout", bout_w[1], 0);
        check("reset ovf", ovf_w[1], 0);
        check("reset in_ready", ir_w[1], 1);
        @(negedge clk);
        rst_n = 1'b1;

        op8(8'd5, 8'd3, 1'b0, 1'b0);
        op8(8'd3, 8'd5, 1'b0, 1'b0);
        op8(8'h80, 8'h01, 1'b0, 1'b0);
        op8(8'h00, 8'h00, 1'b1, 1'b1);

        // Abort an operation after three bits with reset.
        a_w[1]  = MAXW'(8'h55);
        b_w[1]  = MAXW'(8'h22);
        iv_w[1] = 1'b1;
        @(posedge clk);
        #1;
        iv_w[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid-run reset out_valid", ov_w[1], 0);
        check("mid-run reset busy", busy_w[1], 0);
        check("mid-run reset diff", diff_w[1], 0);
        check("mid-run reset bout", bout_w[1], 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (ov_w[1] === 1'b1) n++;
        end
        check("result after reset", n, 0);
        op8(8'h10, 8'h01, 1'b0, 1'b0);

        rnd = 1'b1;
        fork
            drive(0, 60);
            drive(1, 60);
            drive(2, 40);
        join
        n = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("w1 pending results", q[0].size(), 0);
        check("w8 pending results", q[1].size(), 0);
        check("w13 pending results", q[2].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
